// File: rtl/fast_command_scheduler.sv
// fast_command_scheduler: serialises BCR, round-robin requester words or idle words
// into fixed-length fast-command frames, MSB first, one bit per enabled cycle.
module fast_command_scheduler #(
    parameter int                    NREQ         = 4,
    parameter int                    FRAME_BITS   = 8,
    parameter logic [FRAME_BITS-1:0] IDLE_WORD    = 8'hAC,
    parameter logic [FRAME_BITS-1:0] BCR_WORD     = 8'h2D,
    parameter int                    ORBIT_FRAMES = 3564
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       bcr_enable,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*FRAME_BITS-1:0] req_word,
    output logic [NREQ-1:0]            req_ready,
    output logic                       fast_command,
    output logic                       frame_start,
    output logic                       cmd_active,
    output logic [11:0]                orbit_pos
);
    localparam int CW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [CW-1:0]         r_bit_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [11:0]           r_orbit;
    logic [PW-1:0]         r_rr_ptr;
    logic                  r_cmd_active;

    logic                  w_boundary, w_bcr_due, w_any, w_grant;
    logic [PW-1:0]         w_win, w_idx, w_next_rr;
    logic [FRAME_BITS-1:0] w_word;

    // Scan downwards from the farthest requester so the one closest to r_rr_ptr wins last.
    always_comb begin
        w_win = r_rr_ptr;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = PW'((int'(r_rr_ptr) + k) % NREQ);
            if (req_valid[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
    end

    assign w_boundary = enable && (r_bit_cnt == CW'(FRAME_BITS - 1));
    assign w_bcr_due  = bcr_enable && (r_orbit == 12'(ORBIT_FRAMES - 1));
    assign w_grant    = !reset && w_boundary && !w_bcr_due && w_any;
    assign w_next_rr  = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    assign w_word     = req_word[w_win*FRAME_BITS +: FRAME_BITS];
    assign req_ready  = w_grant ? (NREQ'(1) << w_win) : '0;

    // Disable behaves exactly like reset so re-enabling always begins a clean orbit.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_bit_cnt    <= '0;
            r_shift      <= IDLE_WORD;
            r_orbit      <= '0;
            r_rr_ptr     <= '0;
            r_cmd_active <= 1'b0;
        end else if (w_boundary) begin
            r_bit_cnt    <= '0;
            r_orbit      <= (r_orbit == 12'(ORBIT_FRAMES - 1)) ? '0 : r_orbit + 12'd1;
            r_shift      <= w_bcr_due ? BCR_WORD : (w_any ? w_word : IDLE_WORD);
            r_cmd_active <= w_bcr_due || w_any;
            if (w_grant)
                r_rr_ptr <= w_next_rr;
        end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign fast_command = r_shift[FRAME_BITS-1];
    assign frame_start  = enable && (r_bit_cnt == '0);
    assign cmd_active   = r_cmd_active;
    assign orbit_pos    = r_orbit;
endmodule

// File: tb/tb_fast_command_scheduler.sv
// tb_fast_command_scheduler: randomized stimulus, frame-level reference model and
// scoreboard queues for expected frames and grants, checked by an independent monitor.
module tb_fast_command_scheduler;
    localparam int         NREQ = 4;
    localparam int         FB   = 8;
    localparam int         ORB  = 16;
    localparam logic [7:0] IDLE = 8'hAC;
    localparam logic [7:0] BCR  = 8'h2D;

    logic               clk = 1'b0;
    logic               reset, enable, bcr_enable;
    logic [NREQ-1:0]    req_valid, req_ready;
    logic [NREQ*FB-1:0] req_word;
    logic               fast_command, frame_start, cmd_active;
    logic [11:0]        orbit_pos;

    fast_command_scheduler #(
        .NREQ(NREQ), .FRAME_BITS(FB), .IDLE_WORD(IDLE), .BCR_WORD(BCR), .ORBIT_FRAMES(ORB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bcr_enable(bcr_enable),
        .req_valid(req_valid), .req_word(req_word), .req_ready(req_ready),
        .fast_command(fast_command), .frame_start(frame_start),
        .cmd_active(cmd_active), .orbit_pos(orbit_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] w;
        logic       a;
        int         o;
    } frame_t;

    frame_t fq[$];
    int     gq[$];
    int     errors = 0, checks = 0;
    int     m_bit = 0, m_orbit = 0, m_rr = 0, pg = -1;
    bit     m_rstpend = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: decides what each frame carries from the orbit position,
    // a round-robin pointer and the pending requests; queues frames and grants.
    task automatic model_step(output int g);
        frame_t f;
        g = -1;
        if (enable && m_bit == 0) m_rstpend = 0;
        if (reset || !enable) begin
            if (!enable && m_bit == 0 && !m_rstpend && fq.size() > 0) void'(fq.pop_back());
            if (!m_rstpend) fq.push_back('{IDLE, 1'b0, 0});
            m_rstpend = 1;
            m_bit = 0; m_orbit = 0; m_rr = 0;
        end else if (m_bit == FB - 1) begin
            m_bit = 0;
            f.o = (m_orbit + 1) % ORB;
            if (bcr_enable && m_orbit == ORB - 1) begin
                f.w = BCR; f.a = 1'b1;
            end else begin
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
                if (g >= 0) begin
                    f.w = req_word[g*FB +: FB]; f.a = 1'b1;
                    m_rr = (g + 1) % NREQ;
                    gq.push_back(g);
                end else begin
                    f.w = IDLE; f.a = 1'b0;
                end
            end
            m_orbit = f.o;
            fq.push_back(f);
        end else begin
            m_bit++;
        end
    endtask

    task automatic step(input logic rst, input logic en, input int pct, input logic bcr);
        @(posedge clk);
        #1;
        if (pg >= 0) req_valid[pg] = 1'b0;
        for (int i = 0; i < NREQ; i++)
            if (!req_valid[i] && int'($urandom_range(99)) < pct) begin
                req_valid[i] = 1'b1;
                req_word[i*FB +: FB] = 8'($urandom);
            end
        reset = rst; enable = en; bcr_enable = bcr;
        model_step(pg);
    endtask

    // Monitor: pops expected grants and frames only when the DUT presents them.
    initial begin
        int         n = 0, g;
        logic [7:0] bits = '0;
        frame_t     cur;
        forever begin
            @(negedge clk);
            if (reset) check("ready_in_reset", {28'd0, req_ready}, 32'd0);
            if (req_ready !== '0) begin
                if (gq.size() == 0) check("grant_unexpected", {28'd0, req_ready}, 32'd0);
                else begin
                    g = gq.pop_front();
                    check("grant", {28'd0, req_ready}, 32'd1 << g);
                end
            end
            if (enable !== 1'b1) n = 0;
            else if (frame_start) begin
                if (fq.size() == 0) begin
                    check("frame_unexpected", 32'd1, 32'd0);
                    n = 0;
                end else begin
                    cur  = fq.pop_front();
                    n    = 1;
                    bits = {7'd0, fast_command};
                    check("frame_orbit", {20'd0, orbit_pos}, cur.o);
                    check("frame_active", {31'd0, cmd_active}, {31'd0, cur.a});
                end
            end else if (n > 0) begin
                bits = {bits[6:0], fast_command};
                n++;
                if (n == FB) begin
                    check("frame_word", {24'd0, bits}, {24'd0, cur.w});
                    check("frame_active_hold", {31'd0, cmd_active}, {31'd0, cur.a});
                    n = 0;
                end
            end
        end
    end

    initial begin
        int r;
        logic b;
        reset = 1'b1; enable = 1'b0; bcr_enable = 1'b0; req_valid = '0; req_word = '0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        @(negedge clk);
        check("rst_fast_command", {31'd0, fast_command}, 32'd1);
        check("rst_frame_start", {31'd0, frame_start}, 32'd1);
        check("rst_orbit", {20'd0, orbit_pos}, 32'd0);
        check("rst_cmd_active", {31'd0, cmd_active}, 32'd0);
        repeat (44) step(0, 1, 0, 0);
        req_word[2*FB +: FB] = 8'h5A;
        req_valid[2] = 1'b1;
        repeat (24) step(0, 1, 0, 0);
        repeat (160) step(0, 1, 100, 1);
        b = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(999));
            if (r >= 990) b = ~b;
            step(r < 5, !(r >= 5 && r < 10), 8, b);
        end
        repeat (40) step(0, 1, 0, 1);
        check("grants_drained", gq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
